// File: rtl/reg_cmd_decoder_pkg.sv
// Shared definitions for the register command decoder: command byte layout
// and FSM state encoding.
package reg_cmd_pkg;

  localparam int unsigned CMD_RW_BIT    = 7;
  localparam int unsigned CMD_BURST_BIT = 6;
  localparam int unsigned CMD_ADDR_W    = 6;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WSTROBE,
    RSTROBE,
    RLOAD,
    RWAIT
  } state_t;

endpackage

// File: rtl/reg_cmd_decoder.sv
// Bus initiator for the PWM register block: decodes a framed byte stream into
// one-cycle register read/write strobes and returns read bytes to the bridge.
module reg_cmd_decoder
  import reg_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W = CMD_ADDR_W,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_active,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_in,
  output logic              tx_load,
  output logic [DATA_W-1:0] tx_data,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read,
  output logic              err_overrun
);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data_write;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_burst;
  logic                r_frame_done;
  logic                r_frame_d;
  logic                r_err;
  logic                w_latch_cmd;
  logic                w_latch_wdata;
  logic                w_inc_addr;
  logic                w_done;
  logic                w_overrun;
  logic                w_frame_rise;

  assign w_frame_rise = frame_active & ~r_frame_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Strobes decode from the registered state, so a strobe already committed
  // for this cycle completes even if the frame drops underneath it.
  always_comb begin
    w_next        = r_state;
    w_latch_cmd   = 1'b0;
    w_latch_wdata = 1'b0;
    w_inc_addr    = 1'b0;
    w_done        = 1'b0;
    w_overrun     = 1'b0;
    if (!frame_active) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (byte_valid && !r_frame_done) begin
            w_latch_cmd = 1'b1;
            w_next      = byte_in[CMD_RW_BIT] ? WDATA : RSTROBE;
          end
        end
        WDATA: begin
          if (byte_valid) begin
            w_latch_wdata = 1'b1;
            w_next        = WSTROBE;
          end
        end
        WSTROBE: begin
          w_overrun = byte_valid;
          if (r_burst) begin
            w_inc_addr = 1'b1;
            w_next     = WDATA;
          end else begin
            w_done = 1'b1;
            w_next = IDLE;
          end
        end
        RSTROBE: begin
          w_overrun = byte_valid;
          w_next    = RLOAD;
        end
        RLOAD: begin
          w_overrun = byte_valid;
          if (r_burst) begin
            w_next = RWAIT;
          end else begin
            w_done = 1'b1;
            w_next = IDLE;
          end
        end
        RWAIT: begin
          if (byte_valid) begin
            w_inc_addr = 1'b1;
            w_next     = RSTROBE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_data_write <= '0;
      r_tx_data    <= '0;
      r_burst      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_d    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_d <= frame_active;
      if (w_latch_cmd) begin
        r_addr  <= byte_in[ADDR_W-1:0];
        r_burst <= byte_in[CMD_BURST_BIT];
      end else if (w_inc_addr) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_latch_wdata)       r_data_write <= byte_in;
      if (r_state == RSTROBE)  r_tx_data    <= data_read;
      if (!frame_active)       r_frame_done <= 1'b0;
      else if (w_done)         r_frame_done <= 1'b1;
      if (w_overrun)           r_err        <= 1'b1;
      else if (w_frame_rise)   r_err        <= 1'b0;
    end
  end

  assign write       = (r_state == WSTROBE);
  assign read        = (r_state == RSTROBE);
  assign tx_load     = (r_state == RLOAD);
  assign tx_data     = r_tx_data;
  assign addr        = r_addr;
  assign data_write  = r_data_write;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_reg_cmd_decoder.sv
// Directed self-checking bench for reg_cmd_decoder.
module tb_reg_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_active = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = '0;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;
  logic       err_overrun;

  logic [7:0] mem [64];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         overlap = 0;

  int w_addr[$], w_data[$], w_cyc[$];
  int r_addr[$], r_cyc[$];
  int t_data[$], t_cyc[$];

  reg_cmd_decoder #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_active(frame_active),
    .byte_valid(byte_valid), .byte_in(byte_in), .tx_load(tx_load),
    .tx_data(tx_data), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb data_read = mem[addr];

  always @(negedge clk) begin
    if (write) begin
      w_addr.push_back(int'(addr)); w_data.push_back(int'(data_write)); w_cyc.push_back(cyc);
    end
    if (read) begin
      r_addr.push_back(int'(addr)); r_cyc.push_back(cyc);
    end
    if (tx_load) begin
      t_data.push_back(int'(tx_data)); t_cyc.push_back(cyc);
    end
    if ((read && write) || (read && tx_load) || (write && tx_load)) overlap++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    r_addr.delete(); r_cyc.delete();
    t_data.delete(); t_cyc.delete();
  endtask

  task automatic send(input logic [7:0] b, output int c);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    c          = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    byte_valid   = 1'b0;
    frame_active = 1'b1;
    idle(1);
  endtask

  task automatic frame_end();
    @(negedge clk);
    byte_valid   = 1'b0;
    frame_active = 1'b0;
    idle(2);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_eq({pfx, "_tx_load"}, 32'(tx_load), 0);
    check_eq({pfx, "_tx_data"}, 32'(tx_data), 0);
    check_eq({pfx, "_read"}, 32'(read), 0);
    check_eq({pfx, "_write"}, 32'(write), 0);
    check_eq({pfx, "_addr"}, 32'(addr), 0);
    check_eq({pfx, "_data_write"}, 32'(data_write), 0);
    check_eq({pfx, "_err"}, 32'(err_overrun), 0);
  endtask

  initial begin
    int c0, c1, c2;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 5);
    mem[11] = 8'h01;
    mem[8]  = 8'h34;
    mem[9]  = 8'h12;

    idle(2);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single write, trailing bytes ignored until the frame ends
    clear_logs();
    frame_start();
    send(8'h8A, c0); idle(1);
    send(8'h07, c1); idle(1);
    send(8'h81, c2); idle(1);
    send(8'h99, c2); idle(4);
    check_eq("sw_count", w_addr.size(), 1);
    if (w_addr.size() == 1) begin
      check_eq("sw_addr", w_addr[0], 32'h0A);
      check_eq("sw_data", w_data[0], 32'h07);
      check_eq("sw_cycle", w_cyc[0], c1 + 1);
    end
    check_eq("sw_reads", r_addr.size(), 0);
    check_eq("sw_txload", t_data.size(), 0);
    check_eq("sw_no_err", 32'(err_overrun), 0);
    check_eq("sw_addr_hold", 32'(addr), 32'h0A);
    check_eq("sw_data_hold", 32'(data_write), 32'h07);
    frame_end();

    // Single read
    clear_logs();
    frame_start();
    send(8'h0B, c0); idle(5);
    check_eq("sr_count", r_addr.size(), 1);
    if (r_addr.size() == 1) begin
      check_eq("sr_addr", r_addr[0], 32'h0B);
      check_eq("sr_cycle", r_cyc[0], c0 + 1);
    end
    check_eq("sr_tx_count", t_data.size(), 1);
    if (t_data.size() == 1) begin
      check_eq("sr_tx_data", t_data[0], 32'h01);
      check_eq("sr_tx_cycle", t_cyc[0], c0 + 2);
    end
    check_eq("sr_writes", w_addr.size(), 0);
    frame_end();

    // Burst write wrapping 0x3F -> 0x00
    clear_logs();
    frame_start();
    send(8'hFF, c0); idle(1);
    send(8'h11, c1); idle(1);
    send(8'h22, c2); idle(4);
    check_eq("bw_count", w_addr.size(), 2);
    if (w_addr.size() == 2) begin
      check_eq("bw_addr0", w_addr[0], 32'h3F);
      check_eq("bw_data0", w_data[0], 32'h11);
      check_eq("bw_addr1", w_addr[1], 32'h00);
      check_eq("bw_data1", w_data[1], 32'h22);
      check_eq("bw_cycle1", w_cyc[1], c2 + 1);
    end
    frame_end();

    // Burst read with a dummy byte in RWAIT
    clear_logs();
    frame_start();
    send(8'h48, c0); idle(4);
    send(8'hA5, c1); idle(5);
    check_eq("br_count", r_addr.size(), 2);
    if (r_addr.size() == 2) begin
      check_eq("br_addr0", r_addr[0], 32'h08);
      check_eq("br_addr1", r_addr[1], 32'h09);
      check_eq("br_cycle1", r_cyc[1], c1 + 1);
    end
    check_eq("br_tx_count", t_data.size(), 2);
    if (t_data.size() == 2) begin
      check_eq("br_tx0", t_data[0], 32'h34);
      check_eq("br_tx1", t_data[1], 32'h12);
      check_eq("br_tx_cycle1", t_cyc[1], c1 + 2);
    end
    check_eq("br_err", 32'(err_overrun), 0);
    frame_end();

    // Abort: frame drops together with the data byte
    clear_logs();
    frame_start();
    send(8'h83, c0); idle(1);
    @(negedge clk);
    frame_active = 1'b0;
    byte_valid   = 1'b1;
    byte_in      = 8'h55;
    idle(4);
    check_eq("ab_no_write", w_addr.size(), 0);
    frame_start();
    send(8'h83, c0); idle(1);
    send(8'h66, c1); idle(4);
    check_eq("ab_next_count", w_addr.size(), 1);
    if (w_addr.size() == 1) begin
      check_eq("ab_next_addr", w_addr[0], 32'h03);
      check_eq("ab_next_data", w_data[0], 32'h66);
    end
    frame_end();

    // Overrun: byte arrives during the write strobe
    clear_logs();
    frame_start();
    send(8'h85, c0); idle(1);
    send(8'h44, c1);
    send(8'h77, c2); idle(4);
    check_eq("ov_err_set", 32'(err_overrun), 1);
    check_eq("ov_write_count", w_addr.size(), 1);
    if (w_addr.size() == 1) check_eq("ov_write_data", w_data[0], 32'h44);
    frame_end();
    check_eq("ov_err_sticky", 32'(err_overrun), 1);
    frame_start();
    idle(1);
    check_eq("ov_err_clear", 32'(err_overrun), 0);
    frame_end();

    // Reset while waiting for write data
    clear_logs();
    frame_start();
    send(8'h8C, c0); idle(2);
    check_eq("rst_pre_addr", 32'(addr), 32'h0C);
    @(negedge clk);
    rst_n        = 1'b0;
    byte_valid   = 1'b1;
    byte_in      = 8'h5A;
    #1;
    check_zero_outputs("rst_mid");
    idle(2);
    frame_active = 1'b0;
    rst_n        = 1'b1;
    idle(4);
    check_eq("rst_no_write", w_addr.size(), 0);
    check_eq("rst_addr_after", 32'(addr), 0);

    check_eq("no_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
